// File: rtl/mux4_scan_sampler.sv
// -----------------------------------------------------------------------------
// mux4_scan_sampler
//
// Round-robin controller for an external 4:1 bit mux. It drives the select pair
// {s1,s0} through ch0..ch3 and holds each channel for DWELL cycles. At the last
// cycle of each dwell it samples the mux output y. The four samples form a
// 4-bit frame, which is offered downstream over a valid/ready handshake.
//
// Parameters
//   DWELL        cycles each channel stays selected before y is sampled (1..255)
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   en           scan enable (level); dropping it mid-scan aborts the scan
//   s0, s1       registered mux selects (= ch[0], ch[1])
//   y            mux output, sampled at the end of each dwell
//   frame        frame[i] = sample taken while channel i was selected
//   frame_valid  frame holds an unconsumed result
//   frame_ready  downstream consumes frame when frame_valid && frame_ready
//   overrun      sticky drop flag; exists only with MUX4_SCAN_DROP_EN
//
// Configuration macro: MUX4_SCAN_DROP_EN
//   undefined : a frame that completes while the output slot is busy stalls
//               the scan in HOLD (selects parked at 11) until it is delivered.
//   defined   : such a frame is discarded, scanning continues, and the sticky
//               overrun flag is set.
// -----------------------------------------------------------------------------
module mux4_scan_sampler #(
  parameter int DWELL = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  output logic       s0,
  output logic       s1,
  input  logic       y,
  output logic [3:0] frame,
  output logic       frame_valid,
  input  logic       frame_ready
`ifdef MUX4_SCAN_DROP_EN
  ,
  output logic       overrun
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    HOLD = 2'd2
  } state_t;

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  state_t     state_reg, state_next;
  logic [1:0] ch_reg, ch_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [3:0] samp_reg, samp_next;   // partial frame; whole frame while in HOLD
  logic [3:0] frame_reg, frame_next;
  logic       valid_reg, valid_next;
  logic       consume, slot_free, load;
`ifdef MUX4_SCAN_DROP_EN
  logic       ovr_reg, ovr_next;
`endif

  // The selects are the channel register itself, so they only move on a
  // sampling edge and are glitch-free.
  assign s0          = ch_reg[0];
  assign s1          = ch_reg[1];
  assign frame       = frame_reg;
  assign frame_valid = valid_reg;
`ifdef MUX4_SCAN_DROP_EN
  assign overrun     = ovr_reg;
`endif

  // The slot counts as free when it is empty or is emptied at this very edge.
  assign consume   = valid_reg && frame_ready;
  assign slot_free = !valid_reg || frame_ready;

  always_comb begin
    state_next = state_reg;
    ch_next    = ch_reg;
    cnt_next   = cnt_reg;
    samp_next  = samp_reg;
    frame_next = frame_reg;
    load       = 1'b0;
`ifdef MUX4_SCAN_DROP_EN
    ovr_next   = ovr_reg;
`endif

    case (state_reg)
      IDLE: begin
        ch_next  = 2'd0;
        cnt_next = 8'd0;
        if (en) state_next = SCAN;
      end

      SCAN: begin
        if (!en) begin
          // Abort: partial samples are thrown away, the output slot is kept.
          state_next = IDLE;
          ch_next    = 2'd0;
          cnt_next   = 8'd0;
          samp_next  = 4'd0;
        end else if (cnt_reg == DWELL_LAST) begin
          cnt_next          = 8'd0;
          samp_next[ch_reg] = y;
          ch_next           = ch_reg + 2'd1;
          if (ch_reg == 2'd3) begin
            if (slot_free) begin
              frame_next = {y, samp_reg[2:0]};
              load       = 1'b1;
            end else begin
`ifdef MUX4_SCAN_DROP_EN
              ovr_next   = 1'b1;
`else
              // Park on ch3 with the complete frame in samp_reg.
              state_next = HOLD;
              ch_next    = 2'd3;
`endif
            end
          end
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end

`ifndef MUX4_SCAN_DROP_EN
      HOLD: begin
        // en is ignored here: the stalled frame must still be delivered.
        if (consume) begin
          frame_next = samp_reg;
          load       = 1'b1;
          ch_next    = 2'd0;
          cnt_next   = 8'd0;
          state_next = en ? SCAN : IDLE;
        end
      end
`endif

      default: begin
        state_next = IDLE;
        ch_next    = 2'd0;
        cnt_next   = 8'd0;
      end
    endcase

    // A load at the same edge as a consume keeps the slot full.
    if (load)         valid_next = 1'b1;
    else if (consume) valid_next = 1'b0;
    else              valid_next = valid_reg;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      ch_reg    <= 2'd0;
      cnt_reg   <= 8'd0;
      samp_reg  <= 4'd0;
      frame_reg <= 4'd0;
      valid_reg <= 1'b0;
`ifdef MUX4_SCAN_DROP_EN
      ovr_reg   <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      ch_reg    <= ch_next;
      cnt_reg   <= cnt_next;
      samp_reg  <= samp_next;
      frame_reg <= frame_next;
      valid_reg <= valid_next;
`ifdef MUX4_SCAN_DROP_EN
      ovr_reg   <= ovr_next;
`endif
    end
  end

endmodule

// File: tb/tb_mux4_scan_sampler.sv
// -----------------------------------------------------------------------------
// Testbench for mux4_scan_sampler with a real 4:1 mux closing the loop
// (y = d[{s1,s0}]). A scan-position reference model runs in lockstep and is
// compared every cycle. Table-driven frame/latency checks and hand-written
// backpressure, abort and reset sequences are run on top of it.
// -----------------------------------------------------------------------------
module tb_mux4_scan_sampler;

  localparam int DW = 4;
  localparam int FP = 4 * DW;   // cycles per frame

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       en = 1'b0;
  logic       frame_ready = 1'b0;
  logic [3:0] d = 4'd0;
  logic       s0, s1, y;
  logic [3:0] frame;
  logic       frame_valid;
`ifdef MUX4_SCAN_DROP_EN
  logic       overrun;
`endif

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  // The real 4:1 mux being scanned.
  assign y = d[{s1, s0}];

  mux4_scan_sampler #(.DWELL(DW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .s0          (s0),
    .s1          (s1),
    .y           (y),
    .frame       (frame),
    .frame_valid (frame_valid),
    .frame_ready (frame_ready)
`ifdef MUX4_SCAN_DROP_EN
    ,
    .overrun     (overrun)
`endif
  );

  // ---------------- reference model: position within a frame period ---------
  bit         m_scan = 0;
  bit         m_hold = 0;
  int         m_phase = 0;      // 0 .. FP-1 inside a scan
  logic [3:0] m_acc = 4'd0;
  logic [3:0] m_held = 4'd0;
  logic [3:0] m_frame = 4'd0;
  logic       m_valid = 1'b0;
  logic       m_ovr = 1'b0;
  bit         live = 0;

  function automatic int m_sel();
    if (m_hold) return 3;
    if (m_scan) return m_phase / DW;
    return 0;
  endfunction

  // Called just after a rising edge; inputs were stable across that edge.
  task automatic model_step();
    logic my, consume, loaded;
    my      = d[m_sel()];
    consume = m_valid && frame_ready;
    loaded  = 1'b0;
    if (!rst_n) begin
      m_scan = 0; m_hold = 0; m_phase = 0; m_acc = 4'd0;
      m_frame = 4'd0; m_valid = 1'b0; m_ovr = 1'b0; live = 1;
      return;
    end
    if (m_hold) begin
      if (consume) begin
        m_frame = m_held; loaded = 1'b1;
        m_hold = 0; m_scan = en; m_phase = 0;
      end
    end else if (!m_scan) begin
      m_scan = en; m_phase = 0;
    end else if (!en) begin
      m_scan = 0; m_phase = 0;
    end else begin
      if (m_phase % DW == DW - 1) m_acc[m_phase / DW] = my;
      if (m_phase == FP - 1) begin
        if (!m_valid || frame_ready) begin
          m_frame = m_acc; loaded = 1'b1;
        end else begin
`ifdef MUX4_SCAN_DROP_EN
          m_ovr = 1'b1;
`else
          m_hold = 1; m_held = m_acc;
`endif
        end
      end
      m_phase = (m_phase + 1) % FP;
    end
    if (loaded) m_valid = 1'b1;
    else if (consume) m_valid = 1'b0;
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: advance model on the edge, compare everything on the falling edge.
  task automatic cycle();
    @(posedge clk);
    model_step();
    @(negedge clk);
    if (live) begin
      chk("model_sel", {6'd0, s1, s0}, 8'(m_sel()));
      chk("model_frame", {4'd0, frame}, {4'd0, m_frame});
      chk("model_valid", {7'd0, frame_valid}, {7'd0, m_valid});
`ifdef MUX4_SCAN_DROP_EN
      chk("model_overrun", {7'd0, overrun}, {7'd0, m_ovr});
`endif
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
  endtask

  // Returns the number of cycles until frame_valid is seen, 0 on timeout.
  task automatic run_until_valid(output int n);
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      cycle();
      if (frame_valid === 1'b1) begin
        n = i;
        break;
      end
    end
  endtask

  typedef struct {
    logic [3:0] d;
    logic [3:0] exp_frame;
    int         exp_lat;
  } vec_t;

  vec_t vt[4];
  int   n;

  initial begin
    vt[0] = '{4'b1010, 4'b1010, FP + 1};
    vt[1] = '{4'b0110, 4'b0110, FP + 1};
    vt[2] = '{4'b0001, 4'b0001, FP + 1};
    vt[3] = '{4'b1111, 4'b1111, FP + 1};

    // Reset state
    do_reset();
    chk("rst_sel", {6'd0, s1, s0}, 8'd0);
    chk("rst_frame", {4'd0, frame}, 8'd0);
    chk("rst_valid", {7'd0, frame_valid}, 8'd0);

    // Table: first-frame latency, contents, single-cycle pulse, period
    for (int i = 0; i < 4; i++) begin
      do_reset();
      d = vt[i].d; en = 1'b1; frame_ready = 1'b1;
      run_until_valid(n);
      chk("tbl_latency", 8'(n), 8'(vt[i].exp_lat));
      chk("tbl_frame", {4'd0, frame}, {4'd0, vt[i].exp_frame});
      cycle();
      chk("tbl_pulse", {7'd0, frame_valid}, 8'd0);
      for (int j = 0; j < FP - 2; j++) cycle();
      cycle();
      chk("tbl_period", {7'd0, frame_valid}, 8'd1);
      chk("tbl_frame2", {4'd0, frame}, {4'd0, vt[i].exp_frame});
    end

    // Backpressure for two frame periods; new data lands in the next frame
    do_reset();
    d = 4'b1010; en = 1'b1; frame_ready = 1'b0;
    run_until_valid(n);
    chk("bp_frame1", {4'd0, frame}, 8'h0a);
    d = 4'b0110;
    for (int j = 0; j < 2 * FP; j++) cycle();
    chk("bp_stable", {4'd0, frame}, 8'h0a);
    chk("bp_valid", {7'd0, frame_valid}, 8'd1);
`ifdef MUX4_SCAN_DROP_EN
    chk("drop_overrun", {7'd0, overrun}, 8'd1);
`else
    chk("hold_park", {6'd0, s1, s0}, 8'd3);
    frame_ready = 1'b1;
    cycle();
    chk("hold_release_frame", {4'd0, frame}, 8'h06);
    chk("hold_release_valid", {7'd0, frame_valid}, 8'd1);
    chk("hold_restart_ch0", {6'd0, s1, s0}, 8'd0);
`endif

    // en dropped mid-ch1, then full frame after re-enable
    do_reset();
    d = 4'b1100; en = 1'b1; frame_ready = 1'b1;
    for (int j = 0; j < 6; j++) cycle();
    chk("abort_midch1", {6'd0, s1, s0}, 8'd1);
    en = 1'b0;
    cycle();
    chk("abort_sel", {6'd0, s1, s0}, 8'd0);
    chk("abort_valid", {7'd0, frame_valid}, 8'd0);
    for (int j = 0; j < 2 * FP; j++) cycle();
    en = 1'b1;
    run_until_valid(n);
    chk("reenable_latency", 8'(n), 8'(FP + 1));
    chk("reenable_frame", {4'd0, frame}, 8'h0c);

    // Reset while stalled (or dropping)
    do_reset();
    d = 4'b0101; en = 1'b1; frame_ready = 1'b0;
    for (int j = 0; j < 2 * FP + FP / 2; j++) cycle();
    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    chk("midrst_sel", {6'd0, s1, s0}, 8'd0);
    chk("midrst_frame", {4'd0, frame}, 8'd0);
    chk("midrst_valid", {7'd0, frame_valid}, 8'd0);
`ifdef MUX4_SCAN_DROP_EN
    chk("midrst_overrun", {7'd0, overrun}, 8'd0);
`endif

    // Randomized traffic against the model
    for (int j = 0; j < 3000; j++) begin
      en          = ($urandom_range(0, 99) < 92);
      frame_ready = ($urandom_range(0, 99) < 45);
      if ($urandom_range(0, 9) == 0) d = 4'($urandom);
      rst_n       = ($urandom_range(0, 299) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
